// File: rtl/dcache_pkg.sv
// Shared definitions for the banked data-cache array: engine state encoding.
package dcache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FL_RD  = 3'd1,
    ST_FL_OUT = 3'd2,
    ST_FILL   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/spram_param.sv
// One byte lane of the data array: synchronous write with an asynchronous read.
// The read is asynchronous so the owner can register it exactly where it needs the word.
module spram_param #(
  parameter int ADDRBITS     = 5,
  parameter int BANKDATABITS = 8
) (
  input  logic                    clk,
  input  logic [ADDRBITS-1:0]     addr,
  input  logic [BANKDATABITS-1:0] data_in,
  input  logic                    we,
  output logic [BANKDATABITS-1:0] data_out
);

  logic [BANKDATABITS-1:0] mem [0:(2**ADDRBITS)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= data_in;
    end
  end

  assign data_out = mem[addr];

endmodule

// File: rtl/dcache_bankarray.sv
// Byte-lane banked cache data array with a CPU port and a flush/fill streaming engine
// that takes over the shared array address while it walks every word.
module dcache_bankarray #(
  parameter int DATABITS     = 32,
  parameter int ADDRBITS     = 5,
  parameter int MEMSIZE      = 2**ADDRBITS,
  parameter int BANKNUM      = 4,
  parameter int BANKDATABITS = DATABITS / BANKNUM
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDRBITS-1:0] addr,
  input  logic [DATABITS-1:0] data_in,
  input  logic                we,
  input  logic [BANKNUM-1:0]  byteenable,
  output logic [DATABITS-1:0] data_out,
  output logic                cpu_ready,
  input  logic                flush_start,
  input  logic                fill_start,
  output logic [DATABITS-1:0] flush_out,
  output logic [ADDRBITS-1:0] flush_addr,
  output logic                flush_valid,
  input  logic                flush_ready,
  input  logic [DATABITS-1:0] fill_in,
  input  logic                fill_valid,
  output logic                fill_ready,
  output logic                busy,
  output logic                done
);

  import dcache_pkg::*;

  localparam logic [ADDRBITS-1:0] LAST = ADDRBITS'(MEMSIZE - 1);

  state_e              state_q, state_d;
  logic [ADDRBITS-1:0] cnt_q, cnt_d;
  logic [ADDRBITS-1:0] ram_addr;
  logic [DATABITS-1:0] ram_wdata, ram_rdata;
  logic [BANKNUM-1:0]  lane_we;
  logic [DATABITS-1:0] flush_out_q, flush_out_d;
  logic [ADDRBITS-1:0] flush_addr_q, flush_addr_d;
  logic [DATABITS-1:0] rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      flush_out_q  <= '0;
      flush_addr_q <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_out_q  <= flush_out_d;
      flush_addr_q <= flush_addr_d;
      rdata_q      <= ram_rdata;
    end
  end

  // The engine owns the array address outside IDLE; only IDLE and FILL may write.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_out_d  = flush_out_q;
    flush_addr_d = flush_addr_q;
    ram_addr     = cnt_q;
    ram_wdata    = fill_in;
    lane_we      = '0;

    case (state_q)
      ST_IDLE: begin
        ram_addr  = addr;
        ram_wdata = data_in;
        lane_we   = we ? byteenable : '0;
        if (flush_start) begin
          state_d = ST_FL_RD;
          cnt_d   = '0;
        end else if (fill_start) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end
      end
      ST_FL_RD: begin
        flush_out_d  = ram_rdata;
        flush_addr_d = cnt_q;
        state_d      = ST_FL_OUT;
      end
      ST_FL_OUT: begin
        if (flush_ready) begin
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + ADDRBITS'(1);
            state_d = ST_FL_RD;
          end
        end
      end
      ST_FILL: begin
        lane_we = {BANKNUM{fill_valid}};
        if (fill_valid) begin
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + ADDRBITS'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar i = 0; i < BANKNUM; i++) begin : g_lane
    spram_param #(
      .ADDRBITS    (ADDRBITS),
      .BANKDATABITS(BANKDATABITS)
    ) u_lane (
      .clk     (clk),
      .addr    (ram_addr),
      .data_in (ram_wdata[i*BANKDATABITS +: BANKDATABITS]),
      .we      (lane_we[i]),
      .data_out(ram_rdata[i*BANKDATABITS +: BANKDATABITS])
    );
  end

  assign data_out    = rdata_q;
  assign flush_out   = flush_out_q;
  assign flush_addr  = flush_addr_q;
  assign cpu_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign flush_valid = (state_q == ST_FL_OUT);
  assign fill_ready  = (state_q == ST_FILL);
  assign done        = (state_q == ST_DONE);

endmodule
